fsm_sym_packer: RTL

- Downstream consumer of the {m,n} Mealy output stream of the two-input control FSM.
- Samples one 2-bit symbol {m,n} per enabled clock and packs SYMS symbols into one word, first symbol in the MSBs.
- Presents each packed word on a valid/ready port to a logger/UART stage.
- Keeps a saturating count of 2'b11 symbols and a sticky overflow flag for dropped words.

---
 rtl/fsm_sym_packer_pkg.sv | 22 ++
 rtl/fsm_sym_packer_if.sv | 11 +
 rtl/fsm_sym_packer_sym_out_slot.sv | 46 ++++
 rtl/fsm_sym_packer.sv | 95 +++++++++
 4 files changed

// File: rtl/fsm_sym_packer_pkg.sv
// Shared definitions for the {m,n} symbol packer: state encoding,
// the symbol value that is counted, and a width helper for fill_idx.
package fsm_sym_packer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [1:0] SYM_11 = 2'b11;

    // Smallest r with 2**r >= v; used to size the symbol fill counter.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fsm_sym_packer_if.sv
// Valid/ready word stream carrying packed symbol words to a logger/UART stage.
interface fsm_sym_packer_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fsm_sym_packer_sym_out_slot.sv
// Single-entry valid/ready holding register. A word offered while the slot
// is occupied and not draining is dropped and recorded in a sticky flag.
module sym_out_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         ovf
);

    logic accept;

    // The slot can take a new word when empty or when it drains on this edge.
    always_comb begin
        accept = !valid || ready;
    end

    // Hold, load, drain or drop; clr wins over everything else.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid <= 1'b0;
            data  <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
            data  <= '0;
            ovf   <= 1'b0;
        end else if (load) begin
            if (accept) begin
                valid <= 1'b1;
                data  <= load_data;
            end else begin
                ovf   <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fsm_sym_packer.sv
// Packs SYMS consecutive {m,n} symbols (first symbol in the MSBs) into one
// word, hands it to a single-entry output slot, and counts 2'b11 symbols
// with a saturating counter.
module fsm_sym_packer
    import fsm_sym_packer_pkg::*;
#(
    parameter int SYMS  = 4,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        en,
    input  logic                        m,
    input  logic                        n,
    input  logic                        flush,
    input  logic                        clr,
    fsm_sym_packer_if.master            out_if,
    output logic                        ovf,
    output logic [CNT_W-1:0]            hit_cnt,
    output logic [clog2(SYMS+1)-1:0]    fill_idx
);

    localparam int W  = 2 * SYMS;
    localparam int FW = clog2(SYMS + 1);

    state_t       state;
    logic [W-1:0] shreg;
    logic [W-1:0] ins;
    logic [W-1:0] word;
    logic [1:0]   sym;
    logic         last;
    logic         emit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Place the incoming symbol at its slot and decide whether a word leaves
    // the packer on this edge (completion, or flush of a non-empty word).
    always_comb begin
        sym = {m, n};
        ins = '0;
        for (int k = 0; k < SYMS; k++) begin
            if (fill_idx == FW'(k)) begin
                ins[W-1-2*k -: 2] = sym;
            end
        end
        word = en ? (shreg | ins) : shreg;
        last = en && (fill_idx == FW'(SYMS - 1));
        emit = last || (flush && (en || (state == FILL)));
    end

    // Packer FSM: shift register, fill count and the 2'b11 hit counter.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            fill_idx <= '0;
            shreg    <= '0;
            hit_cnt  <= '0;
        end else if (clr) begin
            state    <= IDLE;
            fill_idx <= '0;
            shreg    <= '0;
            hit_cnt  <= '0;
        end else begin
            if (emit) begin
                state    <= IDLE;
                fill_idx <= '0;
                shreg    <= '0;
            end else if (en) begin
                state    <= FILL;
                fill_idx <= fill_idx + FW'(1);
                shreg    <= word;
            end
            if (en && (sym == SYM_11)) begin
                hit_cnt <= sat_inc(hit_cnt);
            end
        end
    end

    sym_out_slot #(
        .W (W)
    ) u_slot (
        .clk       (clk),
        .rst_b     (rst_b),
        .clr       (clr),
        .load      (emit),
        .load_data (word),
        .ready     (out_if.ready),
        .valid     (out_if.valid),
        .data      (out_if.data),
        .ovf       (ovf)
    );

endmodule
